// File: rtl/aud_sram_pkg.sv
// Shared types and constants for the audio SRAM arbiter and its pin-level PHY.
// Optional build macro AUD_ARB_FAIR_EN (used by aud_sram_arbiter) selects round-robin arbitration.
package aud_sram_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RDOUT} state_t;
    typedef enum logic {GNT_WR, GNT_RD} grant_t;
    typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} op_t;

    typedef struct packed {
        logic ce_n;
        logic we_n;
        logic oe_n;
        logic lb_n;
        logic ub_n;
    } sram_ctl_t;

    localparam sram_ctl_t SRAM_INACTIVE = '{ce_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, lb_n: 1'b1, ub_n: 1'b1};

    // Both byte lanes are always enabled; the audio path only moves full 16-bit words.
    function automatic sram_ctl_t sram_ctl_for(op_t op);
        sram_ctl_t c;
        c = SRAM_INACTIVE;
        case (op)
            OP_WRITE: begin
                c.ce_n = 1'b0;
                c.we_n = 1'b0;
                c.lb_n = 1'b0;
                c.ub_n = 1'b0;
            end
            OP_READ: begin
                c.ce_n = 1'b0;
                c.oe_n = 1'b0;
                c.lb_n = 1'b0;
                c.ub_n = 1'b0;
            end
            default: c = SRAM_INACTIVE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aud_sram_phy.sv
// SRAM pin sequencer: access-cycle counter, strobe/DQ drive for the current op, and read capture.
module aud_sram_phy
    import aud_sram_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  op_t               i_op,
    input  logic [DATA_W-1:0] i_sram_dq,
    output sram_ctl_t         o_ctl,
    output logic              o_dq_oe,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    logic [CNT_W-1:0] cnt;

    always_comb begin
        o_done  = 1'b0;
        o_ctl   = sram_ctl_for(i_op);
        o_dq_oe = (i_op == OP_WRITE);
        case (i_op)
            OP_WRITE: o_done = (cnt == CNT_W'(WR_CYCLES - 1));
            OP_READ:  o_done = (cnt == CNT_W'(RD_CYCLES - 1));
            default:  o_done = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_op == OP_IDLE || o_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sample DQ on the edge that closes the last OE_n-low cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
        end else if (i_op == OP_READ && o_done) begin
            o_rd_data <= i_sram_dq;
        end
    end

endmodule

// File: rtl/aud_sram_arbiter.sv
// Arbitrates recorder writes and player reads onto the shared 1M x 16 SRAM and tracks end of recording.
// Build macro AUD_ARB_FAIR_EN: round-robin on contention; undefined gives strict write priority.
module aud_sram_arbiter
    import aud_sram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_clear_end,
    output logic [ADDR_W:0]   o_end_addr,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_dq,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n
);

    state_t    state, state_nxt;
    op_t       op;
    sram_ctl_t ctl;
    logic      phy_done;
    logic      grant_wr, grant_rd;
    logic      wr_done;
    logic [ADDR_W:0] wr_end;

`ifdef AUD_ARB_FAIR_EN
    grant_t last_grant;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == S_IDLE) begin
            if (i_wr_req && i_rd_req) begin
                grant_wr = (last_grant == GNT_RD);
                grant_rd = (last_grant == GNT_WR);
            end else begin
                grant_wr = i_wr_req;
                grant_rd = i_rd_req;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= GNT_RD;
        end else if (grant_wr) begin
            last_grant <= GNT_WR;
        end else if (grant_rd) begin
            last_grant <= GNT_RD;
        end
    end
`else
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == S_IDLE) begin
            grant_wr = i_wr_req;
            grant_rd = i_rd_req & ~i_wr_req;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every transaction returns through S_IDLE, which gives the DQ bus a turnaround cycle.
    always_comb begin
        state_nxt  = state;
        op         = OP_IDLE;
        o_wr_ack   = 1'b0;
        o_rd_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_wr) begin
                    state_nxt = S_WRITE;
                end else if (grant_rd) begin
                    state_nxt = S_READ;
                end
            end
            S_WRITE: begin
                op = OP_WRITE;
                if (phy_done) begin
                    o_wr_ack  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                op = OP_READ;
                if (phy_done) begin
                    state_nxt = S_RDOUT;
                end
            end
            S_RDOUT: begin
                o_rd_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sram_addr <= '0;
            o_sram_dq   <= '0;
        end else if (grant_wr) begin
            o_sram_addr <= i_wr_addr;
            o_sram_dq   <= i_wr_data;
        end else if (grant_rd) begin
            o_sram_addr <= i_rd_addr;
        end
    end

    assign wr_done = (state == S_WRITE) && phy_done;
    assign wr_end  = {1'b0, o_sram_addr} + {{ADDR_W{1'b0}}, 1'b1};

    // A clear in the same cycle as a write completion discards that write's update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_end_addr <= '0;
        end else if (i_clear_end) begin
            o_end_addr <= '0;
        end else if (wr_done && (wr_end > o_end_addr)) begin
            o_end_addr <= wr_end;
        end
    end

    aud_sram_phy #(
        .DATA_W    (DATA_W),
        .WR_CYCLES (WR_CYCLES),
        .RD_CYCLES (RD_CYCLES)
    ) u_phy (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_op      (op),
        .i_sram_dq (i_sram_dq),
        .o_ctl     (ctl),
        .o_dq_oe   (o_sram_dq_oe),
        .o_done    (phy_done),
        .o_rd_data (o_rd_data)
    );

    assign o_sram_ce_n = ctl.ce_n;
    assign o_sram_we_n = ctl.we_n;
    assign o_sram_oe_n = ctl.oe_n;
    assign o_sram_lb_n = ctl.lb_n;
    assign o_sram_ub_n = ctl.ub_n;

endmodule
